// File: rtl/ex_if.sv
// ID/EX operand bundle into the execute stage and the EX/DM register bundle out of it.
interface ex_if #(
  parameter int DW = 16,
  parameter int RW = 3
);
  logic          valid_id;
  logic          flush_ex;
  logic [3:0]    alu_op;
  logic          src_sel;
  logic [DW-1:0] ra_id;
  logic [DW-1:0] rb_id;
  logic [DW-1:0] imm_id;
  logic          mem_en_id;
  logic          mem_rw_id;
  logic          mem_mux_sel_id;
  logic          reg_wr_id;
  logic [RW-1:0] rd_id;

  logic          stall_ex;
  logic [DW-1:0] ans_ex;
  logic [DW-1:0] DM_data;
  logic          mem_en_ex;
  logic          mem_rw_ex;
  logic          mem_mux_sel_dm;
  logic          reg_wr_ex;
  logic [RW-1:0] rd_ex;
  logic          valid_ex;
  logic          zero_ex;

  modport slave (
    input  valid_id, flush_ex, alu_op, src_sel, ra_id, rb_id, imm_id,
           mem_en_id, mem_rw_id, mem_mux_sel_id, reg_wr_id, rd_id,
    output stall_ex, ans_ex, DM_data, mem_en_ex, mem_rw_ex, mem_mux_sel_dm,
           reg_wr_ex, rd_ex, valid_ex, zero_ex
  );

  modport master (
    output valid_id, flush_ex, alu_op, src_sel, ra_id, rb_id, imm_id,
           mem_en_id, mem_rw_id, mem_mux_sel_id, reg_wr_id, rd_id,
    input  stall_ex, ans_ex, DM_data, mem_en_ex, mem_rw_ex, mem_mux_sel_dm,
           reg_wr_ex, rd_ex, valid_ex, zero_ex
  );
endinterface

// File: rtl/ex_block.sv
// 16-bit execute stage: single-cycle ALU, iterative 16-step shift-add multiplier
// that stalls upstream, and the registered EX/DM pipeline outputs.
module ex_block #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic clk,
  input  logic reset,
  ex_if.slave  bus
);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;

  // Single-cycle ALU; MUL and the unused codes yield zero here.
  function automatic logic [DW-1:0] alu_f(input logic [3:0]    op,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic signed [DW-1:0] sa;
    logic signed [DW-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      OP_ADD:  alu_f = a + b;
      OP_SUB:  alu_f = a - b;
      OP_AND:  alu_f = a & b;
      OP_OR:   alu_f = a | b;
      OP_XOR:  alu_f = a ^ b;
      OP_NOT:  alu_f = ~a;
      OP_SLL:  alu_f = a << b[3:0];
      OP_SRL:  alu_f = a >> b[3:0];
      OP_SRA:  alu_f = $unsigned(sa >>> b[3:0]);
      OP_SLT:  alu_f = (sa < sb) ? {{(DW-1){1'b0}}, 1'b1} : '0;
      OP_PASS: alu_f = b;
      default: alu_f = '0;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;

  logic [DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0] mplier_q, mplier_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] m_rb_q, m_rb_d;
  logic [RW-1:0] m_rd_q, m_rd_d;
  logic          m_mem_en_q, m_mem_en_d;
  logic          m_mem_rw_q, m_mem_rw_d;
  logic          m_mux_q, m_mux_d;
  logic          m_reg_wr_q, m_reg_wr_d;

  logic [DW-1:0] ans_q, ans_d;
  logic [DW-1:0] dm_q, dm_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_rw_q, mem_rw_d;
  logic          mux_q, mux_d;
  logic          reg_wr_q, reg_wr_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          valid_q, valid_d;
  logic          zero_q, zero_d;

  logic          stall;
  logic [DW-1:0] b_sel;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] acc_step;

  assign b_sel    = bus.src_sel ? bus.imm_id : bus.rb_id;
  assign alu_res  = alu_f(bus.alu_op, bus.ra_id, b_sel);
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    m_rb_d     = m_rb_q;
    m_rd_d     = m_rd_q;
    m_mem_en_d = m_mem_en_q;
    m_mem_rw_d = m_mem_rw_q;
    m_mux_d    = m_mux_q;
    m_reg_wr_d = m_reg_wr_q;
    // Bubble by default: qualifying controls drop, data outputs hold.
    ans_d      = ans_q;
    dm_d       = dm_q;
    mux_d      = mux_q;
    rd_d       = rd_q;
    zero_d     = zero_q;
    valid_d    = 1'b0;
    mem_en_d   = 1'b0;
    mem_rw_d   = 1'b0;
    reg_wr_d   = 1'b0;
    stall      = 1'b0;

    if (bus.flush_ex) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.valid_id && bus.alu_op == OP_MUL) begin
            stall      = 1'b1;
            mcand_d    = bus.ra_id;
            mplier_d   = b_sel;
            acc_d      = '0;
            cnt_d      = '0;
            m_rb_d     = bus.rb_id;
            m_rd_d     = bus.rd_id;
            m_mem_en_d = bus.mem_en_id;
            m_mem_rw_d = bus.mem_rw_id;
            m_mux_d    = bus.mem_mux_sel_id;
            m_reg_wr_d = bus.reg_wr_id;
            state_d    = S_MUL;
          end else if (bus.valid_id) begin
            ans_d    = alu_res;
            zero_d   = (alu_res == '0);
            dm_d     = bus.rb_id;
            rd_d     = bus.rd_id;
            mux_d    = bus.mem_mux_sel_id;
            valid_d  = 1'b1;
            mem_en_d = bus.mem_en_id;
            mem_rw_d = bus.mem_rw_id;
            reg_wr_d = bus.reg_wr_id;
          end
        end
        S_MUL: begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 4'd1;
          // Last step: product retires while upstream advances on this same edge.
          if (cnt_q == 4'd15) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            ans_d    = acc_step;
            zero_d   = (acc_step == '0);
            dm_d     = m_rb_q;
            rd_d     = m_rd_q;
            mux_d    = m_mux_q;
            valid_d  = 1'b1;
            mem_en_d = m_mem_en_q;
            mem_rw_d = m_mem_rw_q;
            reg_wr_d = m_reg_wr_q;
          end else begin
            stall = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ans_q    <= '0;
      dm_q     <= '0;
      mem_en_q <= 1'b0;
      mem_rw_q <= 1'b0;
      mux_q    <= 1'b0;
      reg_wr_q <= 1'b0;
      rd_q     <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ans_q    <= ans_d;
      dm_q     <= dm_d;
      mem_en_q <= mem_en_d;
      mem_rw_q <= mem_rw_d;
      mux_q    <= mux_d;
      reg_wr_q <= reg_wr_d;
      rd_q     <= rd_d;
      valid_q  <= valid_d;
      zero_q   <= zero_d;
    end
  end

  // Multiplier operands and latched controls are only meaningful once state is S_MUL.
  always_ff @(posedge clk) begin
    mcand_q    <= mcand_d;
    mplier_q   <= mplier_d;
    acc_q      <= acc_d;
    m_rb_q     <= m_rb_d;
    m_rd_q     <= m_rd_d;
    m_mem_en_q <= m_mem_en_d;
    m_mem_rw_q <= m_mem_rw_d;
    m_mux_q    <= m_mux_d;
    m_reg_wr_q <= m_reg_wr_d;
  end

  assign bus.stall_ex       = stall;
  assign bus.ans_ex         = ans_q;
  assign bus.DM_data        = dm_q;
  assign bus.mem_en_ex      = mem_en_q;
  assign bus.mem_rw_ex      = mem_rw_q;
  assign bus.mem_mux_sel_dm = mux_q;
  assign bus.reg_wr_ex      = reg_wr_q;
  assign bus.rd_ex          = rd_q;
  assign bus.valid_ex       = valid_q;
  assign bus.zero_ex        = zero_q;

endmodule

// File: tb/tb_ex_block.sv
// Directed bench for ex_block: ALU vector table plus hand-written multiply, reset-abort and flush-abort sequences.
module tb_ex_block;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ex_if #(.DW(16), .RW(3)) bus ();

  ex_block #(.DW(16), .RW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0]  op;
    logic        src;
    logic [15:0] a;
    logic [15:0] rb;
    logic [15:0] imm;
    logic        men;
    logic        mrw;
    logic        mux;
    logic        rwr;
    logic [2:0]  rd;
    logic [15:0] ans;
    logic        zero;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid_id       = 1'b0;
    bus.flush_ex       = 1'b0;
    bus.alu_op         = 4'd0;
    bus.src_sel        = 1'b0;
    bus.ra_id          = 16'h0;
    bus.rb_id          = 16'h0;
    bus.imm_id         = 16'h0;
    bus.mem_en_id      = 1'b0;
    bus.mem_rw_id      = 1'b0;
    bus.mem_mux_sel_id = 1'b0;
    bus.reg_wr_id      = 1'b0;
    bus.rd_id          = 3'd0;
  endtask

  task automatic drive(input logic [3:0] op, input logic src, input logic [15:0] a,
                       input logic [15:0] rb, input logic [15:0] imm, input logic men,
                       input logic mrw, input logic mux, input logic rwr, input logic [2:0] rd);
    bus.valid_id       = 1'b1;
    bus.flush_ex       = 1'b0;
    bus.alu_op         = op;
    bus.src_sel        = src;
    bus.ra_id          = a;
    bus.rb_id          = rb;
    bus.imm_id         = imm;
    bus.mem_en_id      = men;
    bus.mem_rw_id      = mrw;
    bus.mem_mux_sel_id = mux;
    bus.reg_wr_id      = rwr;
    bus.rd_id          = rd;
  endtask

  initial begin
    int stall_cnt;
    int vld_during;
    int leaks;

    //           op    src   A         rb        imm       men   mrw   mux   rwr   rd    ans       zero
    vecs[0]  = '{4'd0, 1'b0, 16'hFFFF, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0001, 1'b0};
    vecs[1]  = '{4'd1, 1'b0, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 16'h0000, 1'b1};
    vecs[2]  = '{4'd0, 1'b1, 16'h0010, 16'hBEEF, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0014, 1'b0};
    vecs[3]  = '{4'd2, 1'b0, 16'hF0F0, 16'h3C3C, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 16'h3030, 1'b0};
    vecs[4]  = '{4'd3, 1'b0, 16'hF0F0, 16'h0F01, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 16'hFFF1, 1'b0};
    vecs[5]  = '{4'd4, 1'b0, 16'hAAAA, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 16'h5555, 1'b0};
    vecs[6]  = '{4'd5, 1'b0, 16'h00FF, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 16'hFF00, 1'b0};
    vecs[7]  = '{4'd6, 1'b0, 16'h0001, 16'h0013, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0008, 1'b0};
    vecs[8]  = '{4'd7, 1'b0, 16'h8000, 16'h0004, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 16'h0800, 1'b0};
    vecs[9]  = '{4'd8, 1'b0, 16'h8000, 16'h0004, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'hF800, 1'b0};
    vecs[10] = '{4'd9, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0001, 1'b0};
    vecs[11] = '{4'd9, 1'b0, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 16'h0000, 1'b1};
    vecs[12] = '{4'd11, 1'b1, 16'h5555, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 16'h1234, 1'b0};
    vecs[13] = '{4'd12, 1'b0, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 16'h0000, 1'b1};
    vecs[14] = '{4'd1, 1'b0, 16'h0000, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b0};

    // Reset held two cycles
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_ans", bus.ans_ex, 16'h0);
    chk("rst_dm", bus.DM_data, 16'h0);
    chk("rst_valid", bus.valid_ex, 1'b0);
    chk("rst_ctrl", {bus.mem_en_ex, bus.mem_rw_ex, bus.mem_mux_sel_dm, bus.reg_wr_ex, bus.rd_ex, bus.zero_ex}, 8'h00);
    chk("rst_stall", bus.stall_ex, 1'b0);

    // ALU vector table, one instruction per cycle
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].op, vecs[i].src, vecs[i].a, vecs[i].rb, vecs[i].imm,
            vecs[i].men, vecs[i].mrw, vecs[i].mux, vecs[i].rwr, vecs[i].rd);
      #1;
      chk($sformatf("v%0d_stall", i), bus.stall_ex, 1'b0);
      tick();
      chk($sformatf("v%0d_ans", i), bus.ans_ex, vecs[i].ans);
      chk($sformatf("v%0d_zero", i), bus.zero_ex, vecs[i].zero);
      chk($sformatf("v%0d_valid", i), bus.valid_ex, 1'b1);
      chk($sformatf("v%0d_dm", i), bus.DM_data, vecs[i].rb);
      chk($sformatf("v%0d_ctrl", i),
          {bus.mem_en_ex, bus.mem_rw_ex, bus.mem_mux_sel_dm, bus.reg_wr_ex, bus.rd_ex},
          {vecs[i].men, vecs[i].mrw, vecs[i].mux, vecs[i].rwr, vecs[i].rd});
    end

    // Bubble: valid drops, result and zero flag hold
    idle_inputs();
    tick();
    chk("bub_valid", bus.valid_ex, 1'b0);
    chk("bub_ans", bus.ans_ex, 16'hFFFF);
    chk("bub_zero", bus.zero_ex, 1'b0);
    chk("bub_wr", bus.reg_wr_ex, 1'b0);

    // MUL 300*300 -> 0x5F90, 16 stall cycles
    drive(4'd10, 1'b0, 16'd300, 16'd300, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5);
    stall_cnt  = 0;
    vld_during = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!bus.stall_ex) break;
      stall_cnt++;
      tick();
      if (bus.valid_ex) vld_during++;
    end
    chk("mul_stall_cycles", stall_cnt, 16);
    chk("mul_valid_during", vld_during, 0);
    tick();
    chk("mul_ans", bus.ans_ex, 16'h5F90);
    chk("mul_valid", bus.valid_ex, 1'b1);
    chk("mul_ctrl", {bus.mem_mux_sel_dm, bus.reg_wr_ex, bus.rd_ex, bus.zero_ex}, {1'b1, 1'b1, 3'd5, 1'b0});
    drive(4'd0, 1'b0, 16'd1, 16'd2, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    #1;
    chk("post_mul_stall", bus.stall_ex, 1'b0);
    tick();
    chk("post_mul_ans", bus.ans_ex, 16'h0003);
    chk("post_mul_valid", bus.valid_ex, 1'b1);

    // Reset while cnt=7 aborts the multiply
    drive(4'd10, 1'b0, 16'd300, 16'd300, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    tick();
    repeat (7) tick();
    chk("rabort_busy", bus.stall_ex, 1'b1);
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rabort_ans", bus.ans_ex, 16'h0);
    chk("rabort_stall", bus.stall_ex, 1'b0);
    leaks = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.valid_ex || bus.ans_ex != 16'h0 || bus.stall_ex) leaks++;
    end
    chk("rabort_quiet", leaks, 0);

    // Flush at cnt=3 kills the multiply
    drive(4'd0, 1'b0, 16'd3, 16'd4, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    tick();
    chk("pre_flush_ans", bus.ans_ex, 16'h0007);
    drive(4'd10, 1'b0, 16'd3, 16'd4, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    tick();
    repeat (3) tick();
    bus.flush_ex = 1'b1;
    #1;
    chk("flush_stall", bus.stall_ex, 1'b0);
    tick();
    chk("flush_valid", bus.valid_ex, 1'b0);
    chk("flush_ans_hold", bus.ans_ex, 16'h0007);
    drive(4'd0, 1'b0, 16'd10, 16'd20, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
    #1;
    chk("post_flush_stall", bus.stall_ex, 1'b0);
    tick();
    chk("post_flush_ans", bus.ans_ex, 16'h001E);
    chk("post_flush_valid", bus.valid_ex, 1'b1);
    idle_inputs();
    leaks = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.valid_ex || bus.ans_ex != 16'h001E) leaks++;
    end
    chk("flush_quiet", leaks, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
